instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 27 ++
 rtl/instr_mem_loader_imem_ram.sv | 25 ++
 rtl/instr_mem_loader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants, loader state encoding and the byte-lane merge helper
// for the instruction memory loader.
package instr_mem_loader_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_e;

  // Builds the word to store: the new byte lands in its lane, lanes above it are zero.
  function automatic logic [31:0] merge_lane(input logic [23:0] low_bytes,
                                             input logic [7:0]  new_byte,
                                             input logic [1:0]  lane);
    logic [31:0] word;
    case (lane)
      2'd0:    word = {24'h00_0000, new_byte};
      2'd1:    word = {16'h0000, new_byte, low_bytes[7:0]};
      2'd2:    word = {8'h00, new_byte, low_bytes[15:0]};
      default: word = {new_byte, low_bytes};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_mem_loader_imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader that packs little-endian bytes into 32-bit words
// and serves combinational instruction fetches from the loaded image.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          load_start_i,
  input  logic                          byte_valid_i,
  input  logic [7:0]                    byte_data_i,
  input  logic                          byte_last_i,
  output logic                          byte_ready_o,
  output logic                          load_busy_o,
  output logic                          load_done_o,
  output logic                          load_error_o,
  output logic [$clog2(DEPTH_WORDS):0]  word_count_o,
  input  logic [31:0]                   pc_i,
  output logic [31:0]                   instr_o,
  output logic                          imem_error_o
);

  localparam int             CW         = $clog2(DEPTH_WORDS) + 1;
  localparam int             AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH_WORDS);

  ldr_state_e      state_q;
  logic [1:0]      lane_q;
  logic [23:0]     low_bytes_q;
  logic [CW-1:0]   word_count_q;
  logic            load_done_q;
  logic            load_error_q;

  logic            accept_s;
  logic            full_s;
  logic            word_end_s;
  logic            wr_en_s;
  logic [31:0]     wr_word_s;
  logic [31:0]     offset_s;
  logic [31:0]     index_s;
  logic [31:0]     rd_word_s;
  logic            fetch_err_s;

  // A restart pulse wins over a byte offered in the same cycle.
  assign accept_s   = byte_valid_i && (state_q == LDR_LOAD) && !load_start_i;
  assign full_s     = (word_count_q == FULL_COUNT);
  assign word_end_s = byte_last_i || (lane_q == 2'd3);
  assign wr_en_s    = accept_s && !full_s && word_end_s;
  assign wr_word_s  = merge_lane(low_bytes_q, byte_data_i, lane_q);

  // Loader FSM together with its lane, word counter and status flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= LDR_IDLE;
      lane_q       <= 2'd0;
      low_bytes_q  <= 24'h00_0000;
      word_count_q <= {CW{1'b0}};
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (load_start_i) begin
        state_q      <= LDR_LOAD;
        lane_q       <= 2'd0;
        word_count_q <= {CW{1'b0}};
        load_error_q <= 1'b0;
      end else if (accept_s) begin
        if (full_s) begin
          state_q      <= LDR_DONE;
          load_done_q  <= 1'b1;
          load_error_q <= 1'b1;
        end else begin
          case (lane_q)
            2'd0:    low_bytes_q[7:0]   <= byte_data_i;
            2'd1:    low_bytes_q[15:8]  <= byte_data_i;
            2'd2:    low_bytes_q[23:16] <= byte_data_i;
            default: low_bytes_q        <= low_bytes_q;
          endcase
          if (word_end_s) begin
            word_count_q <= word_count_q + CW'(1);
            lane_q       <= 2'd0;
          end else begin
            lane_q <= lane_q + 2'd1;
          end
          if (byte_last_i) begin
            state_q     <= LDR_DONE;
            load_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign byte_ready_o = (state_q == LDR_LOAD);
  assign load_busy_o  = (state_q == LDR_LOAD);
  assign load_done_o  = load_done_q;
  assign load_error_o = load_error_q;
  assign word_count_o = word_count_q;

  // Fetches are refused while a load is rewriting the image.
  assign offset_s    = pc_i - BASE_ADDR;
  assign index_s     = offset_s >> 2;
  assign fetch_err_s = (pc_i[1:0] != 2'b00) || (pc_i < BASE_ADDR) ||
                       (index_s >= {{(32-CW){1'b0}}, word_count_q}) ||
                       (state_q == LDR_LOAD);
  assign imem_error_o = fetch_err_s;
  assign instr_o      = fetch_err_s ? NOP_INSTR : rd_word_s;

  imem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_imem_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en_s),
    .waddr_i (word_count_q[AW-1:0]),
    .wdata_i (wr_word_s),
    .raddr_i (index_s[AW-1:0]),
    .rdata_o (rd_word_s)
  );

endmodule
